regfile_write_queue: RTL and testbench



---
 rtl/regfile_write_queue_if.sv | 33 +++
 rtl/regfile_write_queue.sv | 80 ++++++++
 tb/tb_regfile_write_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: producer, drain and bypass-lookup signals of the register-file write queue
interface regfile_write_queue_if #(
    parameter int REG_WIDTH = 64,
    parameter int NUM_REGS  = 32,
    parameter int DEPTH     = 4
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(DEPTH + 1);
    logic                 in_valid;
    logic                 in_ready;
    logic [RW-1:0]        in_reg;
    logic [REG_WIDTH-1:0] in_data;
    logic                 port_free;
    logic                 RegWrite;
    logic [RW-1:0]        WriteRegister;
    logic [REG_WIDTH-1:0] WriteData;
    logic [RW-1:0]        lookup_reg1;
    logic [RW-1:0]        lookup_reg2;
    logic                 hit1;
    logic                 hit2;
    logic [REG_WIDTH-1:0] hit_data1;
    logic [REG_WIDTH-1:0] hit_data2;
    logic [CW-1:0]        count;
    logic                 empty;
    modport master (
        output in_valid, in_reg, in_data, port_free, lookup_reg1, lookup_reg2,
        input  in_ready, RegWrite, WriteRegister, WriteData, hit1, hit2, hit_data1, hit_data2, count, empty
    );
    modport slave (
        input  in_valid, in_reg, in_data, port_free, lookup_reg1, lookup_reg2,
        output in_ready, RegWrite, WriteRegister, WriteData, hit1, hit2, hit_data1, hit_data2, count, empty
    );
endinterface

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of pending register writebacks drained onto a free write port, with bypass lookup
module regfile_write_queue #(
    parameter int REG_WIDTH = 64,
    parameter int NUM_REGS  = 32,
    parameter int DEPTH     = 4
) (
    input logic                 clk,
    input logic                 reset,
    regfile_write_queue_if.slave bus
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [RW-1:0] ZERO_REG = RW'(NUM_REGS - 1);

    logic [RW-1:0]        reg_q  [DEPTH];
    logic [REG_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 accept, store, pop;
    logic [PW-1:0]        idx;

    // Writes to the zero register complete the handshake but are dropped.
    always_comb begin
        bus.in_ready = (count_q < CW'(DEPTH)) & ~reset;
        accept       = bus.in_valid & bus.in_ready;
        store        = accept & (bus.in_reg != ZERO_REG);
        pop          = (count_q != '0) & bus.port_free;
        wr_ptr_d     = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = count_q + CW'(store) - CW'(pop);
    end

    assign bus.RegWrite      = pop;
    assign bus.WriteRegister = reg_q[rd_ptr_q];
    assign bus.WriteData     = data_q[rd_ptr_q];
    assign bus.count         = count_q;
    assign bus.empty         = (count_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            reg_q[wr_ptr_q]  <= bus.in_reg;
            data_q[wr_ptr_q] <= bus.in_data;
        end
    end

    // Walk entries oldest to youngest so the youngest match overrides; the draining head still counts.
    always_comb begin
        bus.hit1      = 1'b0;
        bus.hit2      = 1'b0;
        bus.hit_data1 = '0;
        bus.hit_data2 = '0;
        idx           = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (reg_q[idx] == bus.lookup_reg1 && bus.lookup_reg1 != ZERO_REG) begin
                    bus.hit1      = 1'b1;
                    bus.hit_data1 = data_q[idx];
                end
                if (reg_q[idx] == bus.lookup_reg2 && bus.lookup_reg2 != ZERO_REG) begin
                    bus.hit2      = 1'b1;
                    bus.hit_data2 = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed scenarios plus random traffic checked against a queue-based model
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int ZR    = 31;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    logic [4:0]  mq_reg [$];
    logic [63:0] mq_dat [$];

    regfile_write_queue_if #(.REG_WIDTH(64), .NUM_REGS(32), .DEPTH(DEPTH)) bus ();
    regfile_write_queue #(.REG_WIDTH(64), .NUM_REGS(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] r, input logic [63:0] d);
        bus.in_valid = v;
        bus.in_reg   = r;
        bus.in_data  = d;
    endtask

    task automatic model_lookup(input logic [4:0] r, output bit hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != ZR)
            for (int i = mq_reg.size() - 1; i >= 0; i--)
                if (!hit && mq_reg[i] == r) begin
                    hit = 1'b1;
                    d   = mq_dat[i];
                end
    endtask

    always @(posedge clk) begin
        bit p, a;
        if (reset) begin
            started = 1'b1;
            mq_reg.delete();
            mq_dat.delete();
        end else if (started) begin
            p = mq_reg.size() > 0 && bus.port_free;
            a = bus.in_valid && mq_reg.size() < DEPTH;
            if (p) begin
                void'(mq_reg.pop_front());
                void'(mq_dat.pop_front());
            end
            if (a && bus.in_reg != ZR) begin
                mq_reg.push_back(bus.in_reg);
                mq_dat.push_back(bus.in_data);
            end
        end
    end

    always @(negedge clk) begin
        int n;
        bit h;
        logic [63:0] d;
        if (started) begin
            n = mq_reg.size();
            chk("m_in_ready", bus.in_ready, (n < DEPTH) && !reset);
            chk("m_count", bus.count, n);
            chk("m_empty", bus.empty, n == 0);
            chk("m_RegWrite", bus.RegWrite, n > 0 && bus.port_free);
            if (n > 0) begin
                chk("m_WriteRegister", bus.WriteRegister, mq_reg[0]);
                chk("m_WriteData", bus.WriteData, mq_dat[0]);
            end
            model_lookup(bus.lookup_reg1, h, d);
            chk("m_hit1", bus.hit1, h);
            chk("m_hit_data1", bus.hit_data1, d);
            model_lookup(bus.lookup_reg2, h, d);
            chk("m_hit2", bus.hit2, h);
            chk("m_hit_data2", bus.hit_data2, d);
        end
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0);
        bus.port_free   = 1'b0;
        bus.lookup_reg1 = 5'd0;
        bus.lookup_reg2 = 5'd0;
        @(negedge clk);
        chk("rst_in_ready0", bus.in_ready, 0);
        step();
        @(negedge clk);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_RegWrite", bus.RegWrite, 0);
        chk("rst_in_ready1", bus.in_ready, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_after", bus.in_ready, 1);

        step();
        drive(1, 3, 64'h1234);
        bus.port_free = 1'b1;
        step();
        drive(0, 0, 0);
        @(negedge clk);
        chk("single_RegWrite", bus.RegWrite, 1);
        chk("single_reg", bus.WriteRegister, 3);
        chk("single_data", bus.WriteData, 64'h1234);
        @(negedge clk);
        chk("single_empty", bus.empty, 1);

        step();
        bus.port_free = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 5'(i), 64'(i * 'h11));
            step();
        end
        drive(0, 0, 0);
        @(negedge clk);
        chk("fill_count", bus.count, 4);
        chk("fill_in_ready", bus.in_ready, 0);
        step();
        bus.port_free = 1'b1;
        @(negedge clk);
        chk("drain_RegWrite1", bus.RegWrite, 1);
        chk("drain_reg1", bus.WriteRegister, 1);
        chk("drain_data1", bus.WriteData, 64'h11);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("drain_RegWrite", bus.RegWrite, 1);
            chk("drain_reg", bus.WriteRegister, k);
            chk("drain_data", bus.WriteData, 64'(k * 'h11));
            chk("drain_in_ready", bus.in_ready, 1);
        end
        @(negedge clk);
        chk("drain_empty", bus.empty, 1);

        step();
        bus.port_free = 1'b0;
        drive(1, 5, 64'hAA);
        step();
        drive(1, 5, 64'hBB);
        step();
        drive(0, 0, 0);
        bus.lookup_reg1 = 5'd5;
        bus.lookup_reg2 = 5'd6;
        @(negedge clk);
        chk("byp_hit1", bus.hit1, 1);
        chk("byp_data1", bus.hit_data1, 64'hBB);
        chk("byp_hit2", bus.hit2, 0);
        chk("byp_data2", bus.hit_data2, 0);
        step();
        bus.port_free = 1'b1;
        step();
        bus.port_free = 1'b0;
        @(negedge clk);
        chk("byp_pop_hit1", bus.hit1, 1);
        chk("byp_pop_data1", bus.hit_data1, 64'hBB);
        chk("byp_pop_count", bus.count, 1);
        step();
        bus.port_free = 1'b1;
        step();
        @(negedge clk);
        chk("byp_empty", bus.empty, 1);

        step();
        drive(1, ZR, 64'hFFFF);
        bus.lookup_reg1 = 5'(ZR);
        @(negedge clk);
        chk("zero_in_ready", bus.in_ready, 1);
        step();
        drive(0, 0, 0);
        @(negedge clk);
        chk("zero_count", bus.count, 0);
        chk("zero_RegWrite", bus.RegWrite, 0);
        chk("zero_hit1", bus.hit1, 0);

        step();
        drive(1, 1, 64'h100);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i < 9) drive(1, 5'(i + 2), 64'(64'h100 + i + 1));
            else drive(0, 0, 0);
            @(negedge clk);
            chk("conc_count", bus.count, 1);
            chk("conc_RegWrite", bus.RegWrite, 1);
            chk("conc_reg", bus.WriteRegister, i + 1);
            chk("conc_data", bus.WriteData, 64'(64'h100 + i));
        end
        step();
        bus.port_free = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(i + 8), 64'(i));
            step();
        end
        drive(0, 0, 0);
        @(negedge clk);
        chk("rst3_count", bus.count, 3);
        step();
        reset = 1'b1;
        drive(1, 7, 64'h77);
        bus.port_free = 1'b1;
        @(negedge clk);
        chk("rst3_in_ready", bus.in_ready, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0);
        @(negedge clk);
        chk("rst3_count_after", bus.count, 0);
        chk("rst3_RegWrite", bus.RegWrite, 0);

        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 6,
                  ($urandom_range(0, 9) == 0) ? 5'(ZR) : 5'($urandom_range(0, 7)),
                  {$urandom, $urandom});
            bus.port_free   = $urandom_range(0, 1);
            bus.lookup_reg1 = ($urandom_range(0, 9) == 0) ? 5'(ZR) : 5'($urandom_range(0, 7));
            bus.lookup_reg2 = 5'($urandom_range(0, 7));
        end
        step();
        reset = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
